// File: rtl/stage_id_target_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stage_id_target_unit_if: request/result bundle of the ID target unit |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface stage_id_target_unit_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int INST_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] pc;
   logic [INST_WIDTH-1:0] inst;
   logic [ADDR_WIDTH-1:0] data_a;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] pc_next_seq;
   logic [ADDR_WIDTH-1:0] bra_addr;
   logic [ADDR_WIDTH-1:0] jal_addr;
   logic [ADDR_WIDTH-1:0] jalr_addr;
   logic [1:0]            kind;
   logic                  misalign;
   logic [ADDR_WIDTH-1:0] ras_pred_addr;
   logic                  ras_pred_valid;

   modport master (
      output in_valid, pc, inst, data_a, flush, out_ready,
      input  in_ready, out_valid, pc_next_seq, bra_addr, jal_addr, jalr_addr,
             kind, misalign, ras_pred_addr, ras_pred_valid
   );

   modport slave (
      input  in_valid, pc, inst, data_a, flush, out_ready,
      output in_ready, out_valid, pc_next_seq, bra_addr, jal_addr, jalr_addr,
             kind, misalign, ras_pred_addr, ras_pred_valid
   );
endinterface
`default_nettype wire

// File: rtl/stage_id_target_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stage_id_target_unit: ID-stage seq/branch/JAL/JALR targets + RAS     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stage_id_target_unit #(
   parameter int ADDR_WIDTH = 64,
   parameter int INST_WIDTH = 32,
   parameter int RAS_DEPTH  = 4,
   parameter int RVC_EN     = 0
) (
   input logic                  clk,
   input logic                  rst_n,
   stage_id_target_unit_if.slave bus
);
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
   localparam logic [1:0] KIND_NONE = 2'b00;
   localparam logic [1:0] KIND_BRA  = 2'b01;
   localparam logic [1:0] KIND_JAL  = 2'b10;
   localparam logic [1:0] KIND_JALR = 2'b11;

   logic                  compressed;
   logic                  in_ready_w, accept;
   logic [ADDR_WIDTH-1:0] b_imm, j_imm, i_imm;
   logic [ADDR_WIDTH-1:0] seq_w, bra_w, jal_w, jalr_w;
   logic [1:0]            kind_w;
   logic                  mis_sel, misalign_w;
   logic [4:0]            rd, rs1;
   logic                  rd_link, rs1_link, ras_push, ras_pop;
   logic                  unused_funct3;

   logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [ADDR_WIDTH-1:0] ras_d [RAS_DEPTH];
   logic [PTR_W-1:0]      ras_top_q, ras_top_d, push_idx;
   logic [CNT_W-1:0]      ras_cnt_q, ras_cnt_d;
   logic                  pred_valid_w;
   logic [ADDR_WIDTH-1:0] pred_addr_w;

   logic                  out_valid_q, out_valid_d;
   logic [ADDR_WIDTH-1:0] seq_q, seq_d, bra_q, bra_d, jal_q, jal_d, jalr_q, jalr_d;
   logic [1:0]            kind_q, kind_d;
   logic                  misalign_q, misalign_d;
   logic [ADDR_WIDTH-1:0] pred_addr_q, pred_addr_d;
   logic                  pred_valid_q, pred_valid_d;

   if (RVC_EN != 0) begin : g_rvc
      assign compressed = (bus.inst[1:0] != 2'b11);
   end else begin : g_no_rvc
      assign compressed = 1'b0;
   end

   assign in_ready_w = !bus.flush && (!out_valid_q || bus.out_ready);
   assign accept     = bus.in_valid && in_ready_w;

   assign b_imm = {{(ADDR_WIDTH-13){bus.inst[31]}}, bus.inst[31], bus.inst[7],
                   bus.inst[30:25], bus.inst[11:8], 1'b0};
   assign j_imm = {{(ADDR_WIDTH-21){bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                   bus.inst[20], bus.inst[30:21], 1'b0};
   assign i_imm = {{(ADDR_WIDTH-12){bus.inst[31]}}, bus.inst[31:20]};

   assign seq_w  = bus.pc + (compressed ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
   assign bra_w  = bus.pc + b_imm;
   assign jal_w  = bus.pc + j_imm;
   assign jalr_w = (bus.data_a + i_imm) & ~ADDR_WIDTH'(1);

   assign rd            = bus.inst[11:7];
   assign rs1           = bus.inst[19:15];
   assign rd_link       = (rd == 5'd1) || (rd == 5'd5);
   assign rs1_link      = (rs1 == 5'd1) || (rs1 == 5'd5);
   assign unused_funct3 = ^bus.inst[14:12];

   always_comb begin
      kind_w = KIND_NONE;
      if (!compressed) begin
         case (bus.inst[6:0])
            7'b1100011: kind_w = KIND_BRA;
            7'b1101111: kind_w = KIND_JAL;
            7'b1100111: kind_w = KIND_JALR;
            default:    kind_w = KIND_NONE;
         endcase
      end
   end

   // With compressed support every target is 2-byte aligned by construction.
   always_comb begin
      case (kind_w)
         KIND_BRA:  mis_sel = bra_w[1];
         KIND_JAL:  mis_sel = jal_w[1];
         KIND_JALR: mis_sel = jalr_w[1];
         default:   mis_sel = 1'b0;
      endcase
      misalign_w = (RVC_EN == 0) ? mis_sel : 1'b0;
   end

   // rd==rs1 (both link) is a push only; differing link regs pop then push.
   assign ras_push = ((kind_w == KIND_JAL) || (kind_w == KIND_JALR)) && rd_link;
   assign ras_pop  = (kind_w == KIND_JALR) && rs1_link && (!rd_link || (rd != rs1));

   always_comb begin
      ras_d        = ras_q;
      ras_top_d    = ras_top_q;
      ras_cnt_d    = ras_cnt_q;
      push_idx     = '0;
      pred_valid_w = 1'b0;
      pred_addr_w  = '0;
      if (accept) begin
         if (ras_pop && (ras_cnt_q != '0)) begin
            pred_valid_w = 1'b1;
            pred_addr_w  = ras_q[ras_top_q];
            ras_top_d    = (ras_top_q == '0) ? PTR_LAST : ras_top_q - 1'b1;
            ras_cnt_d    = ras_cnt_q - 1'b1;
         end
         if (ras_push) begin
            push_idx        = (ras_top_d == PTR_LAST) ? '0 : ras_top_d + 1'b1;
            ras_d[push_idx] = seq_w;
            ras_top_d       = push_idx;
            ras_cnt_d       = (ras_cnt_d == CNT_FULL) ? CNT_FULL : ras_cnt_d + 1'b1;
         end
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q && !bus.out_ready && !bus.flush;
      seq_d        = seq_q;
      bra_d        = bra_q;
      jal_d        = jal_q;
      jalr_d       = jalr_q;
      kind_d       = kind_q;
      misalign_d   = misalign_q;
      pred_addr_d  = pred_addr_q;
      pred_valid_d = pred_valid_q;
      if (accept) begin
         out_valid_d  = 1'b1;
         seq_d        = seq_w;
         bra_d        = bra_w;
         jal_d        = jal_w;
         jalr_d       = jalr_w;
         kind_d       = kind_w;
         misalign_d   = misalign_w;
         pred_addr_d  = pred_addr_w;
         pred_valid_d = pred_valid_w;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ras_q        <= '{default: '0};
         ras_top_q    <= '0;
         ras_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         seq_q        <= '0;
         bra_q        <= '0;
         jal_q        <= '0;
         jalr_q       <= '0;
         kind_q       <= KIND_NONE;
         misalign_q   <= 1'b0;
         pred_addr_q  <= '0;
         pred_valid_q <= 1'b0;
      end else begin
         ras_q        <= ras_d;
         ras_top_q    <= ras_top_d;
         ras_cnt_q    <= ras_cnt_d;
         out_valid_q  <= out_valid_d;
         seq_q        <= seq_d;
         bra_q        <= bra_d;
         jal_q        <= jal_d;
         jalr_q       <= jalr_d;
         kind_q       <= kind_d;
         misalign_q   <= misalign_d;
         pred_addr_q  <= pred_addr_d;
         pred_valid_q <= pred_valid_d;
      end
   end

   assign bus.in_ready       = in_ready_w;
   assign bus.out_valid      = out_valid_q;
   assign bus.pc_next_seq    = seq_q;
   assign bus.bra_addr       = bra_q;
   assign bus.jal_addr       = jal_q;
   assign bus.jalr_addr      = jalr_q;
   assign bus.kind           = kind_q;
   assign bus.misalign       = misalign_q;
   assign bus.ras_pred_addr  = pred_addr_q;
   assign bus.ras_pred_valid = pred_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_stage_id_target_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stage_id_target_unit: vector table + scoreboard bench             |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_stage_id_target_unit;
   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [63:0] data_a;
      logic [1:0]  kind;
      logic [63:0] target;
      logic        mis;
      logic [63:0] pred_addr;
      logic        pred_valid;
   } vec_t;

   typedef struct {
      logic [63:0] seq;
      logic [63:0] bra;
      logic [63:0] jal;
      logic [63:0] jalr;
      logic [1:0]  kind;
      logic        mis;
      logic [63:0] pred_addr;
      logic        pred_valid;
   } res_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stage_id_target_unit_if #(.ADDR_WIDTH(64), .INST_WIDTH(32)) bus ();
   stage_id_target_unit_if #(.ADDR_WIDTH(64), .INST_WIDTH(32)) bus_c ();

   stage_id_target_unit #(.ADDR_WIDTH(64), .INST_WIDTH(32), .RAS_DEPTH(4), .RVC_EN(0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   stage_id_target_unit #(.ADDR_WIDTH(64), .INST_WIDTH(32), .RAS_DEPTH(4), .RVC_EN(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(bus_c));

   int   n_vec  = 0;
   int   n_fail = 0;
   res_t exp_q[$];
   logic model_ov = 1'b0;
   vec_t tbl [25];
   vec_t idle;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_res(input string tag, input res_t g, input res_t e);
      chk({tag, ".seq"},        g.seq,        e.seq);
      chk({tag, ".bra"},        g.bra,        e.bra);
      chk({tag, ".jal"},        g.jal,        e.jal);
      chk({tag, ".jalr"},       g.jalr,       e.jalr);
      chk({tag, ".kind"},       64'(g.kind),  64'(e.kind));
      chk({tag, ".misalign"},   64'(g.mis),   64'(e.mis));
      chk({tag, ".pred_addr"},  g.pred_addr,  e.pred_addr);
      chk({tag, ".pred_valid"}, 64'(g.pred_valid), 64'(e.pred_valid));
   endtask

   function automatic res_t get_res();
      res_t r;
      r.seq = bus.pc_next_seq; r.bra = bus.bra_addr; r.jal = bus.jal_addr; r.jalr = bus.jalr_addr;
      r.kind = bus.kind; r.mis = bus.misalign;
      r.pred_addr = bus.ras_pred_addr; r.pred_valid = bus.ras_pred_valid;
      return r;
   endfunction

   function automatic res_t get_res_c();
      res_t r;
      r.seq = bus_c.pc_next_seq; r.bra = bus_c.bra_addr; r.jal = bus_c.jal_addr; r.jalr = bus_c.jalr_addr;
      r.kind = bus_c.kind; r.mis = bus_c.misalign;
      r.pred_addr = bus_c.ras_pred_addr; r.pred_valid = bus_c.ras_pred_valid;
      return r;
   endfunction

   function automatic vec_t mk(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] da,
                               input logic [1:0] kind, input logic [63:0] tgt, input logic mis,
                               input logic [63:0] pa, input logic pv);
      vec_t v;
      v.pc = pc; v.inst = inst; v.data_a = da; v.kind = kind; v.target = tgt;
      v.mis = mis; v.pred_addr = pa; v.pred_valid = pv;
      return v;
   endfunction

   // Hand-derived target of the decoded kind comes from the vector; the rest from field math.
   function automatic res_t expect_of(input vec_t v);
      res_t r;
      logic signed [12:0] b;
      logic signed [20:0] j;
      logic signed [11:0] i;
      longint bi, ji, ii;
      b  = {v.inst[31], v.inst[7], v.inst[30:25], v.inst[11:8], 1'b0};
      j  = {v.inst[31], v.inst[19:12], v.inst[20], v.inst[30:21], 1'b0};
      i  = v.inst[31:20];
      bi = b; ji = j; ii = i;
      r.seq  = v.pc + 64'd4;
      r.bra  = v.pc + 64'(bi);
      r.jal  = v.pc + 64'(ji);
      r.jalr = (v.data_a + 64'(ii)) & ~64'd1;
      case (v.kind)
         2'b01:   r.bra  = v.target;
         2'b10:   r.jal  = v.target;
         2'b11:   r.jalr = v.target;
         default: ;
      endcase
      r.kind = v.kind; r.mis = v.mis;
      r.pred_addr = v.pred_addr; r.pred_valid = v.pred_valid;
      return r;
   endfunction

   task automatic step(input logic v, input vec_t vec, input logic fl, input logic ordy, input string tag);
      logic rdy_exp, acc;
      @(negedge clk);
      bus.in_valid = v; bus.pc = vec.pc; bus.inst = vec.inst; bus.data_a = vec.data_a;
      bus.flush = fl; bus.out_ready = ordy;
      #1;
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(model_ov));
      rdy_exp = !fl && (!model_ov || ordy);
      chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(rdy_exp));
      if (model_ov) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL %s.scoreboard: got output expected none", tag);
         end else begin
            chk_res(tag, get_res(), exp_q[0]);
            if (ordy || fl) void'(exp_q.pop_front());
         end
      end
      acc = v && rdy_exp;
      if (acc) exp_q.push_back(expect_of(vec));
      model_ov = acc || (model_ov && !ordy && !fl);
   endtask

   task automatic step_c(input vec_t vec, input res_t e, input string tag);
      @(negedge clk);
      bus_c.in_valid = 1'b1; bus_c.pc = vec.pc; bus_c.inst = vec.inst; bus_c.data_a = vec.data_a;
      @(negedge clk);
      bus_c.in_valid = 1'b0;
      #1;
      chk({tag, ".out_valid"}, 64'(bus_c.out_valid), 64'd1);
      chk_res(tag, get_res_c(), e);
   endtask

   initial begin
      res_t zero_r, e;
      vec_t jal_x1, ret_x1;
      zero_r = '{default: '0};
      idle   = '{default: '0};

      tbl[0]  = mk(64'h1000, 32'hFE000CE3, 64'h0,    2'b01, 64'hFF8,  1'b0, 64'h0, 1'b0);
      tbl[1]  = mk(64'h2000, 32'h100000EF, 64'h0,    2'b10, 64'h2100, 1'b0, 64'h0, 1'b0);
      tbl[2]  = mk(64'h2100, 32'h00008067, 64'h2004, 2'b11, 64'h2004, 1'b0, 64'h2004, 1'b1);
      for (int k = 0; k < 5; k++)
         tbl[3+k] = mk(64'h3000 + 64'(k) * 64'h100, 32'h100000EF, 64'h0, 2'b10,
                       64'h3100 + 64'(k) * 64'h100, 1'b0, 64'h0, 1'b0);
      for (int k = 0; k < 4; k++)
         tbl[8+k] = mk(64'h3500, 32'h00008067, 64'h4000, 2'b11, 64'h4000, 1'b0,
                       64'h3404 - 64'(k) * 64'h100, 1'b1);
      tbl[12] = mk(64'h3500, 32'h00008067, 64'h4000, 2'b11, 64'h4000, 1'b0, 64'h0, 1'b0);
      tbl[13] = mk(64'h3600, 32'h00010067, 64'h1002, 2'b11, 64'h1002, 1'b1, 64'h0, 1'b0);
      tbl[14] = mk(64'h3700, 32'hFFC30067, 64'h5001, 2'b11, 64'h4FFC, 1'b0, 64'h0, 1'b0);
      tbl[15] = mk(64'h1000, 32'h00001363, 64'h0,    2'b01, 64'h1006, 1'b1, 64'h0, 1'b0);
      tbl[16] = mk(64'h6002, 32'h00500093, 64'h0,    2'b00, 64'h0,    1'b0, 64'h0, 1'b0);
      tbl[17] = mk(64'h100,  32'hFFDFF06F, 64'h0,    2'b10, 64'hFC,   1'b0, 64'h0, 1'b0);
      tbl[18] = mk(64'h0,    32'hFFDFF06F, 64'h0,    2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b0);
      tbl[19] = mk(64'h7000, 32'h000300E7, 64'h8000, 2'b11, 64'h8000, 1'b0, 64'h0, 1'b0);
      tbl[20] = mk(64'h7100, 32'h000082E7, 64'h9000, 2'b11, 64'h9000, 1'b0, 64'h7004, 1'b1);
      tbl[21] = mk(64'h7200, 32'h000080E7, 64'hA000, 2'b11, 64'hA000, 1'b0, 64'h0, 1'b0);
      tbl[22] = mk(64'h7300, 32'h00028067, 64'hB000, 2'b11, 64'hB000, 1'b0, 64'h7204, 1'b1);
      tbl[23] = mk(64'h7400, 32'h00008067, 64'hB000, 2'b11, 64'hB000, 1'b0, 64'h7104, 1'b1);
      tbl[24] = mk(64'h7500, 32'h00008067, 64'hB000, 2'b11, 64'hB000, 1'b0, 64'h0, 1'b0);

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.pc = '0; bus.inst = '0; bus.data_a = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
      bus_c.in_valid = 1'b0; bus_c.pc = '0; bus_c.inst = '0; bus_c.data_a = '0; bus_c.flush = 1'b0;
      bus_c.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
      chk_res("reset", get_res(), zero_r);
      rst_n = 1'b1;

      for (int k = 0; k < 25; k++) step(1'b1, tbl[k], 1'b0, 1'b1, $sformatf("v%0d", k));
      repeat (2) step(1'b0, idle, 1'b0, 1'b1, "drain0");

      // Back-pressure: output held three cycles while a new request waits.
      step(1'b1, tbl[0], 1'b0, 1'b1, "stall_a");
      repeat (3) step(1'b1, tbl[15], 1'b0, 1'b0, "stall_hold");
      step(1'b1, tbl[15], 1'b0, 1'b1, "stall_go");
      repeat (2) step(1'b0, idle, 1'b0, 1'b1, "stall_drain");

      // Flush kills the pending output and blocks a same-cycle request; RAS push survives.
      jal_x1 = mk(64'h9000, 32'h100000EF, 64'h0, 2'b10, 64'h9100, 1'b0, 64'h0, 1'b0);
      step(1'b1, jal_x1, 1'b0, 1'b1, "fl_push");
      jal_x1.pc = 64'hA000; jal_x1.target = 64'hA100;
      step(1'b1, jal_x1, 1'b1, 1'b0, "fl_kill");
      step(1'b0, idle, 1'b0, 1'b1, "fl_after");
      ret_x1 = mk(64'h9100, 32'h00008067, 64'h9004, 2'b11, 64'h9004, 1'b0, 64'h9004, 1'b1);
      step(1'b1, ret_x1, 1'b0, 1'b1, "fl_ret");
      ret_x1.pred_addr = 64'h0; ret_x1.pred_valid = 1'b0;
      step(1'b1, ret_x1, 1'b0, 1'b1, "fl_ret_empty");
      repeat (2) step(1'b0, idle, 1'b0, 1'b1, "fl_drain");

      // Asynchronous reset in the middle of a transfer discards output and RAS.
      jal_x1 = mk(64'hC000, 32'h100000EF, 64'h0, 2'b10, 64'hC100, 1'b0, 64'h0, 1'b0);
      step(1'b1, jal_x1, 1'b0, 1'b1, "rs_push");
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("rs_async.out_valid", 64'(bus.out_valid), 64'd0);
      exp_q.delete();
      model_ov = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, ret_x1, 1'b0, 1'b1, "rs_ret");
      repeat (2) step(1'b0, idle, 1'b0, 1'b1, "rs_drain");

      // Compressed-enabled instance.
      e = '{seq: 64'h104, bra: 64'h100, jal: 64'h10100, jalr: 64'h1002, kind: 2'b11, mis: 1'b0,
            pred_addr: 64'h0, pred_valid: 1'b0};
      step_c(mk(64'h100, 32'h00010067, 64'h1002, 2'b11, 64'h0, 1'b0, 64'h0, 1'b0), e, "rvc_jalr");
      e = '{seq: 64'h202, bra: 64'h200, jal: 64'h200, jalr: 64'h0, kind: 2'b00, mis: 1'b0,
            pred_addr: 64'h0, pred_valid: 1'b0};
      step_c(mk(64'h200, 32'h00000001, 64'h0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b0), e, "rvc_c16");
      e = '{seq: 64'h1004, bra: 64'h1006, jal: 64'h2000, jalr: 64'h0, kind: 2'b01, mis: 1'b0,
            pred_addr: 64'h0, pred_valid: 1'b0};
      step_c(mk(64'h1000, 32'h00001363, 64'h0, 2'b01, 64'h0, 1'b0, 64'h0, 1'b0), e, "rvc_bne");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
